// File: rtl/clock_display_gen.sv
// HH:MM:SS BCD time-of-day source with mode/increment time setting, driving an 8-digit seven-segment bus.
// Optional CLOCK_BLINK_EN: blanks the field being edited at 2 Hz while in a set state.
module clock_display_gen #(
    parameter int CLK_HZ = 100_000_000,
    parameter int NPorts = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_mode,
    input  logic                btn_inc,
    output logic [NPorts-1:0]   valid_o,
    output logic [NPorts*8-1:0] seg_o,
    output logic                tick_o
);

    localparam int PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    typedef enum logic [1:0] {RUN, SET_HH, SET_MM, SET_SS} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [3:0]    h1, h0, m1, m0, s1, s0;
    logic [NPorts-1:0] blank;

    function automatic logic [7:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 8'h3F;
            4'd1:    enc = 8'h06;
            4'd2:    enc = 8'h5B;
            4'd3:    enc = 8'h4F;
            4'd4:    enc = 8'h66;
            4'd5:    enc = 8'h6D;
            4'd6:    enc = 8'h7D;
            4'd7:    enc = 8'h07;
            4'd8:    enc = 8'h7F;
            4'd9:    enc = 8'h6F;
            default: enc = 8'h00;
        endcase
    endfunction

`ifdef CLOCK_BLINK_EN
    localparam int BLINK_DIV = CLK_HZ / 4;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    always_comb begin
        blank = '0;
        if (blink_phase) begin
            case (state)
                SET_HH:  blank = NPorts'(8'hC0);
                SET_MM:  blank = NPorts'(8'h18);
                SET_SS:  blank = NPorts'(8'h03);
                default: blank = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || btn_mode || state == RUN) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_MAX) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`else
    always_comb blank = '0;
`endif

    always_ff @(posedge clk) begin
        tick_o <= 1'b0;
        if (rst) begin
            state   <= RUN;
            presc   <= '0;
            {h1, h0, m1, m0, s1, s0} <= '0;
            valid_o <= '0;
            seg_o   <= '0;
        end else begin
            // Display reflects the time/state registers as they were before this edge.
            valid_o <= ~blank;
            seg_o   <= {enc(h1), enc(h0), 8'h40, enc(m1), enc(m0), 8'h40, enc(s1), enc(s0)};
            case (state)
                RUN: begin
                    if (presc == PRESC_MAX) begin
                        presc  <= '0;
                        tick_o <= 1'b1;
                        if (s0 != 4'd9) s0 <= s0 + 4'd1;
                        else begin
                            s0 <= '0;
                            if (s1 != 4'd5) s1 <= s1 + 4'd1;
                            else begin
                                s1 <= '0;
                                if (m0 != 4'd9) m0 <= m0 + 4'd1;
                                else begin
                                    m0 <= '0;
                                    if (m1 != 4'd5) m1 <= m1 + 4'd1;
                                    else begin
                                        m1 <= '0;
                                        if (h1 == 4'd2 && h0 == 4'd3) {h1, h0} <= '0;
                                        else if (h0 == 4'd9) begin
                                            h0 <= '0;
                                            h1 <= h1 + 4'd1;
                                        end else h0 <= h0 + 4'd1;
                                    end
                                end
                            end
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                    if (btn_mode) begin
                        state <= SET_HH;
                        presc <= '0;
                    end
                end
                SET_HH: begin
                    if (btn_mode) state <= SET_MM;
                    else if (btn_inc) begin
                        if (h1 == 4'd2 && h0 == 4'd3) {h1, h0} <= '0;
                        else if (h0 == 4'd9) begin
                            h0 <= '0;
                            h1 <= h1 + 4'd1;
                        end else h0 <= h0 + 4'd1;
                    end
                end
                SET_MM: begin
                    if (btn_mode) state <= SET_SS;
                    else if (btn_inc) begin
                        if (m0 != 4'd9) m0 <= m0 + 4'd1;
                        else begin
                            m0 <= '0;
                            m1 <= (m1 == 4'd5) ? 4'd0 : m1 + 4'd1;
                        end
                    end
                end
                SET_SS: begin
                    if (btn_mode) state <= RUN;
                    else if (btn_inc) {s1, s0} <= '0;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_display_gen.sv
// Randomized and directed checks of clock_display_gen (CLK_HZ=8) against a seconds-of-day reference model.
module tb_clock_display_gen;

    localparam int HZ = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_mode = 1'b0;
    logic        btn_inc = 1'b0;
    logic [7:0]  valid_o;
    logic [63:0] seg_o;
    logic        tick_o;

    int nvec = 0;
    int nerr = 0;

    // reference model state
    int          t_sec = 0;
    int          mst = 0;
    int          mpresc = 0;
    int          mn = 0;
    logic [63:0] e_seg = '0;
    logic [7:0]  e_valid = '0;
    logic        e_tick = 1'b0;
    logic [7:0]  lut [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    clock_display_gen #(.CLK_HZ(HZ), .NPorts(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .valid_o  (valid_o),
        .seg_o    (seg_o),
        .tick_o   (tick_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] disp(input int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {lut[h / 10], lut[h % 10], 8'h40, lut[m / 10], lut[m % 10], 8'h40, lut[s / 10], lut[s % 10]};
    endfunction

    function automatic logic [7:0] valid_of(input int st, input int n);
`ifdef CLOCK_BLINK_EN
        if ((n / (HZ / 4)) % 2 == 1) begin
            if (st == 1) return 8'h3F;
            if (st == 2) return 8'hE7;
            if (st == 3) return 8'hFC;
        end
`endif
        return 8'hFF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        assert (got === exp)
        else begin
            nerr++;
            $error("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the pre-edge state.
    task automatic model_edge(input logic r, input logic m, input logic i);
        if (r) begin
            t_sec = 0; mst = 0; mpresc = 0; mn = 0;
            e_seg = '0; e_valid = '0; e_tick = 1'b0;
            return;
        end
        e_seg   = disp(t_sec);
        e_valid = valid_of(mst, mn);
        e_tick  = 1'b0;
        if (mst == 0) begin
            if (mpresc == HZ - 1) begin
                t_sec  = (t_sec + 1) % 86400;
                e_tick = 1'b1;
                mpresc = 0;
            end else mpresc++;
            if (m) begin mst = 1; mpresc = 0; mn = 0; end
        end else if (m) begin
            mst = (mst + 1) % 4;
            mn = 0;
        end else begin
            mn++;
            if (i) begin
                case (mst)
                    1: t_sec = (((t_sec / 3600) + 1) % 24) * 3600 + t_sec % 3600;
                    2: t_sec = (t_sec / 3600) * 3600 + ((((t_sec / 60) % 60) + 1) % 60) * 60 + t_sec % 60;
                    3: t_sec = t_sec - t_sec % 60;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic step(input logic r, input logic m, input logic i);
        rst = r; btn_mode = m; btn_inc = i;
        @(posedge clk);
        model_edge(r, m, i);
        #1;
        chk("seg", seg_o, e_seg);
        chk("valid", {56'd0, valid_o}, {56'd0, e_valid});
        chk("tick", {63'd0, tick_o}, {63'd0, e_tick});
        rst = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic incs(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b1);
    endtask

    int ticks;

    initial begin
        // T1 reset
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
        chk("rst_seg", seg_o, 64'd0);
        chk("rst_valid", {56'd0, valid_o}, 64'd0);
        idle(2);
        chk("post_rst_seg", seg_o, 64'h3F3F_403F_3F40_3F3F);
        chk("post_rst_valid", {56'd0, valid_o}, 64'hFF);

        // T2 count: 61 ticks from reset
        step(1'b1, 1'b0, 1'b0);
        ticks = 0;
        for (int k = 0; k < HZ * 61; k++) begin
            step(1'b0, 1'b0, 1'b0);
            if (tick_o) ticks++;
        end
        chk("tick_count", 64'(ticks), 64'd61);
        idle(1);
        chk("t2_seg", seg_o, 64'h3F3F_403F_0640_3F06);

        // T4 edit sequence
        step(1'b0, 1'b1, 1'b0);
        incs(25);
        step(1'b0, 1'b1, 1'b0);
        idle(6);
        incs(60);
        step(1'b0, 1'b1, 1'b0);
        incs(1);
        step(1'b0, 1'b1, 1'b0);
        idle(HZ + 2);

        // T5 collision: mode+inc in SET_HH, then inc in RUN
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        idle(3);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        incs(5);
        idle(2);

        // T6 reset during SET_MM
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        incs(3);
        step(1'b1, 1'b0, 1'b0);
        idle(HZ + 2);

        // T3 rollover: set 23:59, run to 23:59:59, then one more tick
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        incs(23);
        step(1'b0, 1'b1, 1'b0);
        incs(59);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(HZ * 59);
        idle(1);
        chk("t3_235959", seg_o, 64'h5B4F_406D_6F40_6D6F);
        idle(HZ);
        chk("t3_rollover", seg_o, 64'h3F3F_403F_3F40_3F3F);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 399) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
